// File: rtl/scan_sequencer.sv
// Raster scan sequencer: steps the mux across an NX x NY grid, triggers one ADC
// conversion per point and hands each sample to the UART controller.
module scan_sequencer #(
    parameter int NX          = 32,
    parameter int NY          = 32,
    parameter int SETTLE      = 16,
    parameter int ADC_TIMEOUT = 1023
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        scan_en,
    output logic [4:0]  mux_x,
    output logic [8:0]  mux_y,
    output logic        adc_start,
    input  logic        adc_valid,
    input  logic [23:0] adc_data,
    output logic [31:0] tx_data,
    output logic        tx_sync,
    output logic        tx_head,
    output logic        tx_tail,
    input  logic        tx_done,
    output logic [15:0] frame_count,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CONVERT,
        ST_WAIT_ADC,
        ST_SEND,
        ST_WAIT_TX,
        ST_ADVANCE
    } state_t;

    localparam logic [4:0]  X_LAST       = 5'(NX - 1);
    localparam logic [8:0]  Y_LAST       = 9'(NY - 1);
    localparam logic [7:0]  SETTLE_LAST  = 8'(SETTLE - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(ADC_TIMEOUT - 1);

    state_t      state;
    logic [7:0]  settle_cnt;
    logic [15:0] wait_cnt;

    logic        x_wrap;
    logic        last_point;
    logic [4:0]  next_x;
    logic [8:0]  next_y;

    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        x_wrap     = (mux_x == X_LAST);
        last_point = x_wrap && (mux_y == Y_LAST);
        next_x     = x_wrap ? 5'd0 : mux_x + 5'd1;
        next_y     = last_point ? 9'd0 : (x_wrap ? mux_y + 9'd1 : mux_y);
    end

    assign busy = (state != ST_IDLE);

    // NOTE: state and outputs are registers, so only non-blocking assignments appear below.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            settle_cnt  <= 8'd0;
            wait_cnt    <= 16'd0;
            mux_x       <= 5'd0;
            mux_y       <= 9'd0;
            adc_start   <= 1'b0;
            tx_data     <= 32'd0;
            tx_sync     <= 1'b0;
            tx_head     <= 1'b0;
            tx_tail     <= 1'b0;
            frame_count <= 16'd0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (scan_en) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= 8'd0;
                        tx_head    <= (mux_x == 5'd0) && (mux_y == 9'd0);
                        tx_tail    <= (mux_x == X_LAST) && (mux_y == Y_LAST);
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state     <= ST_CONVERT;
                        adc_start <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + 8'd1;
                    end
                end
                ST_CONVERT: begin
                    adc_start <= 1'b0;
                    wait_cnt  <= 16'd0;
                    state     <= ST_WAIT_ADC;
                end
                ST_WAIT_ADC: begin
                    // A sample arriving on the expiry cycle is still taken.
                    if (adc_valid) begin
                        tx_data <= {8'h00, adc_data};
                        tx_sync <= 1'b1;
                        state   <= ST_SEND;
                    end else if (wait_cnt == TIMEOUT_LAST) begin
                        timeout_err <= 1'b1;
                        tx_data     <= 32'd0;
                        tx_sync     <= 1'b1;
                        state       <= ST_SEND;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                ST_SEND: begin
                    tx_sync <= 1'b0;
                    state   <= ST_WAIT_TX;
                end
                ST_WAIT_TX: begin
                    if (tx_done) state <= ST_ADVANCE;
                end
                ST_ADVANCE: begin
                    mux_x      <= next_x;
                    mux_y      <= next_y;
                    tx_head    <= (next_x == 5'd0) && (next_y == 9'd0);
                    tx_tail    <= (next_x == X_LAST) && (next_y == Y_LAST);
                    settle_cnt <= 8'd0;
                    // Only the end of a frame may stop the scan.
                    if (last_point) begin
                        frame_count <= frame_count + 16'd1;
                        state       <= scan_en ? ST_SETTLE : ST_IDLE;
                    end else begin
                        state <= ST_SETTLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 Parameter NX, 32: columns per frame, 1..32.
REQ-002 Parameter NY, 32: rows per frame, 1..512.
REQ-003 Parameter SETTLE, 16: mux settle cycles before each conversion, 1..255.
REQ-004 Parameter ADC_TIMEOUT, 1023: maximum cycles waited for adc_valid, 1..65535.
REQ-005 Port clock  in  1  system clock; every register updates on its rising edge.
REQ-006 Port reset  in  1  synchronous, active-high reset.
REQ-007 Port scan_en  in  1  level; enables continuous frame scanning.
REQ-008 Port mux_x  out  5  column demux address.
REQ-009 Port mux_y  out  9  row demux address.
REQ-010 Port adc_start  out  1  one-cycle conversion request.
REQ-011 Port adc_valid  in  1  one-cycle pulse; adc_data valid.
REQ-012 Port adc_data  in  24  conversion result.
REQ-013 Port tx_data  out  32  {8'h00, sample} word to the UART controller.
REQ-014 Port tx_sync  out  1  one-cycle start-of-transfer pulse.
REQ-015 Port tx_head  out  1  level; current point is (0,0).
REQ-016 Port tx_tail  out  1  level; current point is (NX-1,NY-1).
REQ-017 Port tx_done  in  1  one-cycle pulse; transfer of tx_data complete.
REQ-018 Port frame_count  out  16  completed frames, wraps 16'hFFFF->0.
REQ-019 Port busy  out  1  high in every state except IDLE.
REQ-020 Port timeout_err  out  1  sticky ADC timeout flag.

Function
REQ-021 FSM states SHALL be IDLE, SETTLE, CONVERT, WAIT_ADC, SEND, WAIT_TX, ADVANCE.
REQ-022 IDLE->SETTLE when scan_en=1; mux_x/mux_y are held at the current point throughout SETTLE..ADVANCE.
REQ-023 SETTLE SHALL last exactly SETTLE cycles, then CONVERT.
REQ-024 CONVERT SHALL last one cycle with adc_start=1, then WAIT_ADC; adc_start=0 in all other states.
REQ-025 WAIT_ADC: on adc_valid latch {8'h00, adc_data} into tx_data, go SEND; adc_valid in any other state is ignored.
REQ-026 WAIT_ADC after ADC_TIMEOUT cycles without adc_valid: set timeout_err, tx_data=32'h0, go SEND (frame alignment preserved); adc_valid on the same cycle as expiry wins.
REQ-027 SEND SHALL last one cycle with tx_sync=1, then WAIT_TX; tx_data, tx_head, tx_tail stable from SEND until ADVANCE.
REQ-028 WAIT_TX waits indefinitely for tx_done, then ADVANCE; tx_done in other states is ignored.
REQ-029 ADVANCE (one cycle): x increments; at x=NX-1, x->0 and y increments; x is the inner loop.
REQ-030 ADVANCE at last point: y->0, frame_count+1, next state SETTLE if scan_en=1 else IDLE.
REQ-031 ADVANCE otherwise: next state SETTLE regardless of scan_en (a frame, once started, always completes).
REQ-032 NX=1 or NY=1: head and tail both asserted when NX=NY=1; wrap rules unchanged.

Reset
REQ-033 While reset=1: state=IDLE, mux_x=0, mux_y=0, adc_start=0, tx_sync=0, tx_head=0, tx_tail=0, tx_data=0, frame_count=0, timeout_err=0, all counters 0.
REQ-034 Reset mid-frame SHALL abandon the frame without incrementing frame_count; next frame starts at (0,0) with tx_head=1.
REQ-035 timeout_err SHALL clear only on reset.

Verification
REQ-036 NX=2,NY=2,SETTLE=2, scan_en=1, ADC answers 3 cycles after adc_start, UART tx_done 5 cycles after tx_sync -> 4 tx_sync pulses at points (0,0),(1,0),(0,1),(1,1); head on 1st only, tail on 4th only; frame_count=1.
REQ-037 adc_data=24'hA5B6C7 -> tx_data=32'h00A5B6C7 at tx_sync and held until tx_done.
REQ-038 ADC_TIMEOUT=8, no adc_valid -> timeout_err=1 after 8 WAIT_ADC cycles, tx_sync with tx_data=0, scan continues.
REQ-039 scan_en dropped at point (1,0) -> remaining points sent, frame_count increments, FSM ends in IDLE, busy=0.
REQ-040 reset during WAIT_TX at (1,1) -> all outputs at reset values; frame_count=0; restart begins at (0,0) with tx_head=1.
REQ-041 Spurious adc_valid in SETTLE and tx_done in WAIT_ADC -> no state change, no data latched.
